// File: rtl/wb_exception_unit.sv
`default_nettype none
// ============================================================================
// Module      : wb_exception_unit
// Description : Writeback-stage register-file port plus exception
//               entry/flush/redirect/return sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_2000,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_read_data,
  input  logic [4:0]  wb_rd,
  input  logic        wb_mem_to_reg,
  input  logic        wb_reg_write,
  input  logic        wb_exception,
  input  logic [31:0] wb_faulty_address,
  input  logic [31:0] wb_pc,
  input  logic        iret,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        flush,
  output logic        wait_inst,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [31:0] rm0_epc,
  output logic [31:0] rm1_fault_addr,
  output logic        supervisor,
  output logic        double_fault
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FLUSH    = 3'd1;
  localparam logic [2:0] ST_REDIRECT = 3'd2;
  localparam logic [2:0] ST_HANDLER  = 3'd3;
  localparam logic [2:0] ST_RETURN   = 3'd4;

  // Counter is preloaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] fault_q, fault_d;
  logic        sup_q, sup_d;
  logic        dfault_q, dfault_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    epc_d    = epc_q;
    fault_d  = fault_q;
    sup_d    = sup_q;
    dfault_d = dfault_q;
    case (state_q)
      ST_IDLE: begin
        if (wb_exception) begin
          epc_d   = wb_pc;
          fault_d = wb_faulty_address;
          cnt_d   = CNT_INIT;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        sup_d   = 1'b1;
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        // A fault inside the handler keeps the original EPC so iret resumes the first fault.
        if (wb_exception) begin
          dfault_d = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = ST_FLUSH;
        end else if (iret) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        sup_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      epc_q    <= 32'd0;
      fault_q  <= 32'd0;
      sup_q    <= 1'b0;
      dfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      epc_q    <= epc_d;
      fault_q  <= fault_d;
      sup_q    <= sup_d;
      dfault_q <= dfault_d;
    end
  end

  assign rf_we = wb_reg_write && !wb_exception && (wb_rd != 5'd0) &&
                 ((state_q == ST_IDLE) || (state_q == ST_HANDLER));
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_mem_to_reg ? wb_read_data : wb_result;

  assign flush          = (state_q == ST_FLUSH) || (state_q == ST_RETURN);
  assign wait_inst      = (state_q == ST_FLUSH) || (state_q == ST_REDIRECT);
  assign redirect_valid = (state_q == ST_REDIRECT) || (state_q == ST_RETURN);
  assign redirect_pc    = (state_q == ST_REDIRECT) ? EXC_VECTOR :
                          (state_q == ST_RETURN)   ? epc_q      : 32'd0;

  assign rm0_epc        = epc_q;
  assign rm1_fault_addr = fault_q;
  assign supervisor     = sup_q;
  assign double_fault   = dfault_q;

endmodule
`default_nettype wire
